register_file_arbiter: RTL and testbench
========================================

# register_file_arbiter

Round-robin arbiter that shares the single-write-port register file between `Requesters` independent masters, such as the datapath sequencer, a DMA loader and a debug port. Each cycle it grants exactly one pending request. It drives the register file's write enable, address-A and write-data lines, and returns read data through a registered, one-cycle response path. Register-file port B is passed through as a non-arbitrated peek port.

## Interface
Parameters:
- `AddressWidth`, default 6: register address width; must match the register file.
- `RegisterWidth`, default 16: data width.
- `Requesters`, default 4: number of masters, valid range 2..8.

Ports:
- `Clock`  in  1  the single clock; all state updates on its rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `Req`  in  Requesters  per-requester request valid.
- `Write`  in  Requesters  per-requester operation: 1 = write, 0 = read.
- `ReqAddress`  in  Requesters*AddressWidth  per-requester address; slice i is requester i.
- `ReqWriteData`  in  Requesters*RegisterWidth  per-requester write data.
- `Grant`  out  Requesters  one-hot grant (combinational). A transfer is accepted when `Req[i] & Grant[i]`.
- `RespValid`  out  Requesters  registered read-response strobe, one-hot.
- `RespData`  out  RegisterWidth  registered read data.
- `RfWriteEnable`  out  1  drives the register file's write enable.
- `RfAddressA`  out  AddressWidth  drives the register file's address A.
- `RfWriteData`  out  RegisterWidth  drives the register file's write data.
- `RfReadDataA`  in  RegisterWidth  from the register file's read port A.
- `PeekAddress`  in  AddressWidth  passed straight to the register file's address B.
- `RfAddressB`  out  AddressWidth  equals `PeekAddress`.
- `RfReadDataB`  in  RegisterWidth  from the register file's read port B.
- `PeekData`  out  RegisterWidth  equals `RfReadDataB`, combinational.

## Operation
- Priority pointer `Ptr`, range 0..Requesters-1.
- The winner is the first requester with `Req` set, searching from `Ptr` upward with wrap-around. `Grant` is one-hot on the winner, or all zero if no request is pending.
- Datapath mux:
  - `RfAddressA` = winner's address.
  - `RfWriteData` = winner's data.
  - `RfWriteEnable` = `Req[w] & Write[w]`.
  - With no winner: `RfAddressA` = 0, `RfWriteData` = 0, `RfWriteEnable` = 0.
- On an accepted transfer:
  - `Ptr` <= (w+1) mod Requesters, wrapping from Requesters-1 to 0.
  - With no accepted transfer, `Ptr` holds.
- On an accepted read, at the next edge:
  - `RespData` <= `RfReadDataA`.
  - `RespValid` <= one-hot(w).
- `RespValid` is a single-cycle pulse. `RespData` holds its last value when `RespValid` is 0.
- A requester must hold `Req`, `Write`, address and data stable until it is granted.
- Reset values, asserted asynchronously on `nReset` low:
  - `Ptr` = 0, `RespValid` = 0, `RespData` = 0.
  - `Grant` = 0 and `RfWriteEnable` = 0 while `nReset` is low.
- Reset mid-transfer: the in-flight read response is discarded and no write occurs during reset.

## Timing
- Grant latency is 0 cycles (combinational from `Req`). Throughput is one transfer per cycle.
- A write commits at the accepting edge.
- A read response appears one cycle after acceptance.
- A read accepted at cycle t+1 returns data written at cycle t, from any requester.
- `PeekData` is combinational. In the write cycle it shows the old value, and the new value from t+1.
- No starvation: a continuously asserted `Req` is granted within `Requesters` cycles (lock disabled).

## Configuration
- `REGFILE_ARB_LOCK_EN` defined:
  - Adds input `Lock` [Requesters].
  - An accepted transfer with `Lock[w]`=1 makes w the owner. While locked, `Grant` only goes to the owner and `Ptr` is frozen.
  - Lock releases on an accepted owner transfer with `Lock`=0, or on any cycle where the owner's `Req`=0. `Ptr` then becomes owner+1.
  - Reset clears the lock.
- Undefined: the `Lock` port is absent and arbitration is pure round-robin.

## Test plan
- Reset then idle: with `nReset` low and `Req`=4'b1111, `Grant`=0 and `RfWriteEnable`=0. After release, the first grant goes to requester 0.
- Single write then read: requester 2 writes 16'hBEEF to address 5. Requester 2 then reads address 5 and gets `RespValid`=4'b0100 with `RespData`=16'hBEEF one cycle later.
- Fairness: `Req`=4'b1111 held for 8 cycles gives the grant sequence 0,1,2,3,0,1,2,3. With `Req`=4'b1010, the grants alternate 1,3.
- Cross-requester RAW: requester 0 writes 16'h1234 to address 9 at t, and requester 1 reads address 9 at t+1, receiving `RespData`=16'h1234. `PeekData` on address 9 shows 16'h1234 from t+1.
- Reset mid-read: a read is accepted and `nReset` is pulsed before the next edge; `RespValid` stays 0 and `Ptr` is 0.
- (`REGFILE_ARB_LOCK_EN`) Requester 3 performs 3 locked writes while `Req`=4'b1111. `Grant` stays 4'b1000 until the `Lock`=0 transfer, and then the next grant is requester 0.

Source files
------------

// File: rtl/register_file_arbiter.sv
// -----------------------------------------------------------------------------
// register_file_arbiter
//
// Round-robin arbiter sharing the single write port (port A) of a register
// file between Requesters independent masters. One pending request is granted
// per cycle. Writes go straight to the register file. Read data is returned
// through a registered response path one cycle after acceptance. Port B of
// the register file is passed through as an unarbitrated peek port.
//
// Optional feature macro: REGFILE_ARB_LOCK_EN
//   When defined, adds the Lock input. A requester can then hold exclusive
//   ownership of the port across several transfers.
//
// Parameters:
//   AddressWidth   register address width (must match the register file)
//   RegisterWidth  register data width
//   Requesters     number of masters, 2..8
//
// Ports:
//   Clock, nReset            clock, asynchronous active-low reset
//   Req, Write               per-requester request valid / 1=write 0=read
//   Lock                     per-requester lock request (REGFILE_ARB_LOCK_EN)
//   ReqAddress, ReqWriteData per-requester address / write data, slice i = i
//   Grant                    one-hot combinational grant
//   RespValid, RespData      registered read response strobe / data
//   RfWriteEnable, RfAddressA, RfWriteData, RfReadDataA   register file port A
//   PeekAddress, PeekData    peek request / data, wired to port B
//   RfAddressB, RfReadDataB  register file port B
// -----------------------------------------------------------------------------
module register_file_arbiter #(
    parameter int AddressWidth  = 6,
    parameter int RegisterWidth = 16,
    parameter int Requesters    = 4
) (
    input  logic                              Clock,
    input  logic                              nReset,
    input  logic [Requesters-1:0]             Req,
    input  logic [Requesters-1:0]             Write,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic [Requesters-1:0]             Lock,
`endif
    input  logic [Requesters*AddressWidth-1:0]  ReqAddress,
    input  logic [Requesters*RegisterWidth-1:0] ReqWriteData,
    output logic [Requesters-1:0]             Grant,
    output logic [Requesters-1:0]             RespValid,
    output logic [RegisterWidth-1:0]          RespData,
    output logic                              RfWriteEnable,
    output logic [AddressWidth-1:0]           RfAddressA,
    output logic [RegisterWidth-1:0]          RfWriteData,
    input  logic [RegisterWidth-1:0]          RfReadDataA,
    input  logic [AddressWidth-1:0]           PeekAddress,
    output logic [AddressWidth-1:0]           RfAddressB,
    input  logic [RegisterWidth-1:0]          RfReadDataB,
    output logic [RegisterWidth-1:0]          PeekData
);

    localparam int PtrWidth = $clog2(Requesters);

    typedef logic [PtrWidth-1:0] idx_t;

    idx_t                    ptr;
    idx_t                    win;
    logic                    found;
    logic                    accept;
    logic [Requesters-1:0]   eligible;
    logic [Requesters-1:0]   grant_c;
    logic [Requesters-1:0]   resp_valid;
    logic [RegisterWidth-1:0] resp_data;

    // Increment with wrap from Requesters-1 back to 0 (Requesters need not be
    // a power of two).
    function automatic idx_t next_index(input idx_t i);
        if (i == idx_t'(Requesters - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

`ifdef REGFILE_ARB_LOCK_EN
    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } lock_state_t;

    lock_state_t lock_state;
    idx_t        owner;

    // While locked only the owner may compete.
    always_comb begin
        eligible = Req;
        if (lock_state == ARB_LOCKED) begin
            eligible        = '0;
            eligible[owner] = Req[owner];
        end
    end
`else
    always_comb begin
        eligible = Req;
    end
`endif

    // Search from ptr upward with wrap-around; first eligible requester wins.
    always_comb begin
        logic [PtrWidth:0] cand;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < Requesters; k++) begin
            cand = {1'b0, ptr} + (PtrWidth+1)'(k);
            if (cand >= (PtrWidth+1)'(Requesters)) begin
                cand = cand - (PtrWidth+1)'(Requesters);
            end
            if (!found && eligible[cand[PtrWidth-1:0]]) begin
                found = 1'b1;
                win   = cand[PtrWidth-1:0];
            end
        end
    end

    // Gating with nReset keeps Grant and the write enable low during reset.
    assign accept = found & nReset;

    always_comb begin
        grant_c = '0;
        if (accept) begin
            grant_c[win] = 1'b1;
        end
    end

    assign Grant = grant_c;

    // Port A datapath mux; all zero when nothing is granted.
    always_comb begin
        RfAddressA    = '0;
        RfWriteData   = '0;
        RfWriteEnable = 1'b0;
        if (accept) begin
            RfAddressA    = ReqAddress[int'(win)*AddressWidth +: AddressWidth];
            RfWriteData   = ReqWriteData[int'(win)*RegisterWidth +: RegisterWidth];
            RfWriteEnable = Write[win];
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ptr        <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
`ifdef REGFILE_ARB_LOCK_EN
            lock_state <= ARB_FREE;
            owner      <= '0;
`endif
        end else begin
            resp_valid <= '0;
            if (accept && !Write[win]) begin
                resp_valid <= grant_c;
                resp_data  <= RfReadDataA;
            end
`ifdef REGFILE_ARB_LOCK_EN
            case (lock_state)
                ARB_FREE: begin
                    if (accept) begin
                        ptr <= next_index(win);
                        if (Lock[win]) begin
                            lock_state <= ARB_LOCKED;
                            owner      <= win;
                        end
                    end
                end
                ARB_LOCKED: begin
                    // Only the owner can be accepted here, so win == owner.
                    // Ptr stays frozen until the lock is released.
                    if (!Req[owner] || (accept && !Lock[owner])) begin
                        lock_state <= ARB_FREE;
                        ptr        <= next_index(owner);
                    end
                end
                default: begin
                    lock_state <= ARB_FREE;
                end
            endcase
`else
            if (accept) begin
                ptr <= next_index(win);
            end
`endif
        end
    end

    assign RespValid  = resp_valid;
    assign RespData   = resp_data;

    // Unarbitrated peek port.
    assign RfAddressB = PeekAddress;
    assign PeekData   = RfReadDataB;

endmodule

// File: tb/tb_register_file_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for register_file_arbiter. A behavioural register file sits on
// ports A/B. The reference model tracks the round-robin pointer as an integer,
// the register contents as an array, and queues expected read responses for
// an independent monitor.
// -----------------------------------------------------------------------------
module tb_register_file_arbiter;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int RW = 16;

    logic              Clock = 1'b0;
    logic              nReset;
    logic [N-1:0]      Req;
    logic [N-1:0]      Write;
    logic [N*AW-1:0]   ReqAddress;
    logic [N*RW-1:0]   ReqWriteData;
    logic [N-1:0]      Grant;
    logic [N-1:0]      RespValid;
    logic [RW-1:0]     RespData;
    logic              RfWriteEnable;
    logic [AW-1:0]     RfAddressA;
    logic [RW-1:0]     RfWriteData;
    logic [RW-1:0]     RfReadDataA;
    logic [AW-1:0]     PeekAddress;
    logic [AW-1:0]     RfAddressB;
    logic [RW-1:0]     RfReadDataB;
    logic [RW-1:0]     PeekData;
`ifdef REGFILE_ARB_LOCK_EN
    logic [N-1:0]      Lock = '0;
`endif

    register_file_arbiter #(
        .AddressWidth (AW),
        .RegisterWidth(RW),
        .Requesters   (N)
    ) dut (
        .Clock        (Clock),
        .nReset       (nReset),
        .Req          (Req),
        .Write        (Write),
`ifdef REGFILE_ARB_LOCK_EN
        .Lock         (Lock),
`endif
        .ReqAddress   (ReqAddress),
        .ReqWriteData (ReqWriteData),
        .Grant        (Grant),
        .RespValid    (RespValid),
        .RespData     (RespData),
        .RfWriteEnable(RfWriteEnable),
        .RfAddressA   (RfAddressA),
        .RfWriteData  (RfWriteData),
        .RfReadDataA  (RfReadDataA),
        .PeekAddress  (PeekAddress),
        .RfAddressB   (RfAddressB),
        .RfReadDataB  (RfReadDataB),
        .PeekData     (PeekData)
    );

    always #5 Clock = ~Clock;

    // Behavioural register file: synchronous write, asynchronous reads.
    logic [RW-1:0] rf [0:(1<<AW)-1];
    initial for (int i = 0; i < (1<<AW); i++) rf[i] = '0;
    always @(posedge Clock) if (RfWriteEnable) rf[RfAddressA] <= RfWriteData;
    assign RfReadDataA = rf[RfAddressA];
    assign RfReadDataB = rf[RfAddressB];

    // Reference model state.
    logic [RW-1:0] mmem [0:(1<<AW)-1];
    int            mptr;
    logic          pend  [N];
    logic          pwr   [N];
    logic [AW-1:0] paddr [N];
    logic [RW-1:0] pdata [N];

    typedef struct {
        logic [N-1:0]  v;
        logic [RW-1:0] d;
    } resp_t;
    resp_t         exp_q[$];
    logic [RW-1:0] last_d;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Monitor: compares every cycle's response against the scoreboard.
    initial begin
        forever begin
            resp_t e;
            @(posedge Clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("resp_valid", 64'(RespValid), 64'(e.v));
                check("resp_data", 64'(RespData), 64'(e.d));
                last_d = e.d;
            end else begin
                check("resp_idle", 64'(RespValid), 64'(0));
                check("resp_hold", 64'(RespData), 64'(last_d));
            end
        end
    end

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            Req[i]                    = pend[i];
            Write[i]                  = pwr[i];
            ReqAddress[i*AW +: AW]    = paddr[i];
            ReqWriteData[i*RW +: RW]  = pdata[i];
        end
    endtask

    // One cycle: drive inputs, check combinational outputs against the model,
    // then advance the model as the DUT will at the next rising edge.
    task automatic step(input bit hold);
        int           w;
        logic [N-1:0] eg;
        @(negedge Clock);
        apply();
        #1;
        w = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mptr + k) % N;
            if (w < 0 && pend[i]) w = i;
        end
        eg = (w >= 0) ? onehot(w) : '0;
        check("grant", 64'(Grant), 64'(eg));
        check("rf_we", 64'(RfWriteEnable), 64'((w >= 0) ? pwr[w] : 1'b0));
        check("rf_addr_a", 64'(RfAddressA), 64'((w >= 0) ? paddr[w] : '0));
        check("rf_wdata", 64'(RfWriteData), 64'((w >= 0 && pwr[w]) ? pdata[w] :
                                                 (w >= 0) ? pdata[w] : '0));
        check("peek_data", 64'(PeekData), 64'(mmem[PeekAddress]));
        check("rf_addr_b", 64'(RfAddressB), 64'(PeekAddress));
        if (w >= 0) begin
            if (pwr[w]) mmem[paddr[w]] = pdata[w];
            else exp_q.push_back('{v: eg, d: mmem[paddr[w]]});
            mptr = (w + 1) % N;
            if (!hold) pend[w] = 1'b0;
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
    endtask

    initial begin
        int fair_a [8];
        int fair_b [4];
        fair_a = '{0, 1, 2, 3, 0, 1, 2, 3};
        fair_b = '{1, 3, 1, 3};

        for (int i = 0; i < (1<<AW); i++) mmem[i] = '0;
        mptr   = 0;
        last_d = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1; pwr[i] = 1'b1; paddr[i] = AW'(i); pdata[i] = RW'(16'h1111 * (i + 1));
        end

        // Reset with every requester asking to write: nothing may be granted.
        nReset      = 1'b0;
        PeekAddress = '0;
        apply();
        #3;
        check("reset_grant", 64'(Grant), 64'(0));
        check("reset_we", 64'(RfWriteEnable), 64'(0));
        check("reset_resp_valid", 64'(RespValid), 64'(0));
        check("reset_resp_data", 64'(RespData), 64'(0));
        repeat (2) @(negedge Clock);
        Req = '0;
        clear_reqs();
        nReset = 1'b1;

        // Fairness with all four reading.
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1; pwr[i] = 1'b0; paddr[i] = AW'(i);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b1);
            check("fair_all", 64'(Grant), 64'(onehot(fair_a[k])));
        end
        pend[0] = 1'b0;
        pend[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            check("fair_1010", 64'(Grant), 64'(onehot(fair_b[k])));
        end
        clear_reqs();

        // Requester 2 writes then reads back address 5.
        pend[2] = 1'b1; pwr[2] = 1'b1; paddr[2] = 6'd5; pdata[2] = 16'hBEEF;
        step(1'b0);
        pend[2] = 1'b1; pwr[2] = 1'b0; paddr[2] = 6'd5;
        step(1'b0);
        @(posedge Clock);
        #2;
        check("beef_valid", 64'(RespValid), 64'(4'b0100));
        check("beef_data", 64'(RespData), 64'(16'hBEEF));

        // Cross-requester read-after-write, with the peek port on the address.
        PeekAddress = 6'd9;
        pend[0] = 1'b1; pwr[0] = 1'b1; paddr[0] = 6'd9; pdata[0] = 16'h1234;
        step(1'b0);
        pend[1] = 1'b1; pwr[1] = 1'b0; paddr[1] = 6'd9;
        step(1'b0);
        check("raw_peek", 64'(PeekData), 64'(16'h1234));
        @(posedge Clock);
        #2;
        check("raw_valid", 64'(RespValid), 64'(4'b0010));
        check("raw_data", 64'(RespData), 64'(16'h1234));

        // Reset pulse between acceptance of a read and the returning edge.
        pend[3] = 1'b1; pwr[3] = 1'b0; paddr[3] = 6'd5;
        step(1'b0);
        #1;
        nReset = 1'b0;
        Req    = '0;
        clear_reqs();
        exp_q.delete();
        mptr   = 0;
        last_d = '0;
        #1;
        check("midreset_grant", 64'(Grant), 64'(0));
        check("midreset_resp_valid", 64'(RespValid), 64'(0));
        check("midreset_resp_data", 64'(RespData), 64'(0));
        #1;
        nReset = 1'b1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1; pwr[i] = 1'b1; paddr[i] = AW'(16 + i); pdata[i] = RW'($urandom);
        end
        step(1'b1);
        check("ptr_after_reset", 64'(Grant), 64'(4'b0001));
        clear_reqs();

        // Randomised traffic; requests stay stable until granted.
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    pwr[i]   = 1'($urandom_range(0, 1));
                    paddr[i] = AW'($urandom_range(0, 7));
                    pdata[i] = RW'($urandom);
                end
            end
            PeekAddress = AW'($urandom_range(0, 7));
            step(1'b0);
        end

        clear_reqs();
        repeat (3) step(1'b0);
        check("drain", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
